controlador_de_salidas: RTL and testbench
=========================================

Name: controlador_de_salidas

Overview:
Sequencer for the output manager (Administrador_de_salidas) of MicroUAZ. Accepts one bus transaction request from the control unit and drives the output manager's 2-bit selector for the whole transaction. Runs a valid/ready handshake with external memory/IO, with setup cycles, wait states and a timeout. Returns read data and a done/error status to the control unit.

Parameters:
DATA_W, 8, width of bus read data and the o_rdata register
SETUP_CYC, 1, cycles the selector is held stable before o_bus_valid rises (range 1..7)
TIMEOUT, 15, maximum ACCESS cycles without i_bus_ready before error; 0 disables the timeout
IDLE_SEL, 0, selector value driven while no transaction is active

Ports:
clk  input  1  system clock, rising edge
rst  input  1  synchronous, active-high reset
i_start  input  1  transaction request, sampled only in IDLE
i_sel  input  2  selector code for the requested transaction
i_rw  input  1  ReadWrite from the output manager; 1 = write, 0 = read
o_sel_salidas  output  2  selector to the output manager's Sel_Salidas
o_bus_valid  output  1  address/data on the bus are valid
i_bus_ready  input  1  memory/IO accepts the write or presents read data
i_bus_rdata  input  DATA_W  read data from memory/IO
o_rdata  output  DATA_W  last successfully read byte
o_busy  output  1  high when state != IDLE
o_done  output  1  one-cycle pulse on successful completion
o_error  output  1  one-cycle pulse on timeout

Behaviour:
- Interface: one clock, clk; rst is synchronous and active-high.
- Reset, sampled on a clk edge: state IDLE, o_sel_salidas = IDLE_SEL, o_bus_valid = 0, o_rdata = 0, o_busy = 0, o_done = 0, o_error = 0. Counters cleared.
- IDLE: o_sel_salidas = IDLE_SEL. If i_start = 1, latch i_sel into sel_q and i_rw into rw_q, then go to SETUP.
- SETUP: o_sel_salidas = sel_q. Stay for SETUP_CYC cycles, then go to ACCESS.
- ACCESS: o_sel_salidas = sel_q, o_bus_valid = 1.
  - If i_bus_ready = 1, go to DONE. If rw_q = 0, latch i_bus_rdata into o_rdata on the same edge.
  - Else, if TIMEOUT != 0 and the wait count equals TIMEOUT-1, go to ERR.
  - Else increment the wait count.
  - If i_bus_ready arrives on the final allowed cycle, completion wins over timeout.
- DONE: o_done = 1 for one cycle, o_bus_valid = 0, o_sel_salidas = sel_q, then go to IDLE.
- ERR: o_error = 1 for one cycle, o_bus_valid = 0, o_rdata unchanged, then go to IDLE.
- Latency with SETUP_CYC = 1 and zero-wait memory:
  - i_start sampled at edge 0.
  - SETUP in cycle 1.
  - ACCESS in cycle 2, with i_bus_ready high.
  - o_done high in cycle 3.
  - The next i_start is accepted at the edge ending cycle 4 (IDLE).
- Latency in general: done = 2 + SETUP_CYC + wait cycles. Error occurs 1 + SETUP_CYC + TIMEOUT cycles after start.
- i_start while o_busy = 1 is ignored; it is not queued.
- i_bus_ready outside ACCESS is ignored.
- i_sel and i_rw changes after the latch have no effect until the next transaction.
- o_rdata holds its value across writes, errors and IDLE. It changes only on a successful read.
- rst mid-transaction: o_bus_valid drops at that edge. No o_done or o_error is produced. State is IDLE on the next cycle.
- o_done and o_error are never high together. The FSM is Moore except for the o_rdata latch.

Decomposition:
- Package salidas_pkg holds:
  - the state encoding (IDLE, SETUP, ACCESS, DONE, ERR);
  - selector code constants SEL_0..SEL_3;
  - the read/write constants RW_READ = 0 and RW_WRITE = 1.
- Sub-module contador_de_espera: a loadable up-counter with clear, enable and a terminal-count flag. Instantiated once for SETUP and once for the ACCESS timeout.

Test Plan:
- Reset, then idle 5 cycles -> o_sel_salidas = 0 and all outputs 0.
- Write: i_sel = 2, i_rw = 1, i_start for 1 cycle, ready in the first ACCESS cycle -> o_sel_salidas = 2 from cycle 1; o_bus_valid high only in cycle 2; o_done in cycle 3; o_rdata = 0.
- Read with 3 wait states: i_sel = 1, i_rw = 0, i_bus_rdata = 0x5A, ready in the 4th ACCESS cycle -> o_rdata = 0x5A and o_done in cycle 6; o_busy high in cycles 1..6.
- Timeout with TIMEOUT = 15 and ready never asserted -> o_error in cycle 17; o_rdata unchanged; o_done never asserted; back in IDLE at cycle 18.
- Boundary: ready on the 15th ACCESS cycle -> o_done, not o_error.
- i_start pulsed while busy -> ignored, only one o_done produced.
- rst asserted in the 2nd ACCESS cycle -> o_bus_valid = 0 on the next cycle; o_sel_salidas = 0; no o_done or o_error pulse.

Source files
------------

// File: rtl/salidas_pkg.sv
// Shared types and constants for the output-manager sequencer of MicroUAZ.
package salidas_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SETUP  = 3'd1,
    ACCESS = 3'd2,
    DONE   = 3'd3,
    ERR    = 3'd4
  } state_e;

  localparam logic [1:0] SEL_0 = 2'd0;
  localparam logic [1:0] SEL_1 = 2'd1;
  localparam logic [1:0] SEL_2 = 2'd2;
  localparam logic [1:0] SEL_3 = 2'd3;

  localparam logic RW_READ  = 1'b0;
  localparam logic RW_WRITE = 1'b1;

  // Wide enough for SETUP_CYC (1..7) and TIMEOUT up to 256.
  localparam int unsigned CNT_W = 8;

endpackage

// File: rtl/contador_de_espera.sv
// Loadable up-counter with clear, enable and a terminal-count flag.
module contador_de_espera #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_clr,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  input  logic         i_en,
  input  logic [W-1:0] i_term,
  output logic         o_tc_c
);

  logic [W-1:0] cnt_q, cnt_d;

  // Clear beats load, load beats increment.
  always_comb begin
    cnt_d = cnt_q;
    if (i_clr) begin
      cnt_d = '0;
    end else if (i_load) begin
      cnt_d = i_load_val;
    end else if (i_en) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign o_tc_c = (cnt_q == i_term);

endmodule

// File: rtl/controlador_de_salidas.sv
// Bus transaction sequencer: holds the output-manager selector, runs the
// valid/ready handshake with setup cycles and timeout, reports done/error.
module controlador_de_salidas
  import salidas_pkg::*;
#(
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned SETUP_CYC = 1,
  parameter int unsigned TIMEOUT   = 15,
  parameter logic [1:0]  IDLE_SEL  = SEL_0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_start,
  input  logic [1:0]        i_sel,
  input  logic              i_rw,
  output logic [1:0]        o_sel_salidas,
  output logic              o_bus_valid,
  input  logic              i_bus_ready,
  input  logic [DATA_W-1:0] i_bus_rdata,
  output logic [DATA_W-1:0] o_rdata,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_error
);

  localparam logic [CNT_W-1:0] SETUP_TERM = CNT_W'(SETUP_CYC - 1);
  localparam logic [CNT_W-1:0] WAIT_TERM  = (TIMEOUT == 0) ? '0 : CNT_W'(TIMEOUT - 1);

  state_e            state_q, state_d;
  logic [1:0]        sel_q, sel_d;
  logic              rw_q, rw_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic [1:0]        sel_out_q, sel_out_d;
  logic              valid_q, valid_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              error_q, error_d;

  logic cnt_clr, setup_en, wait_en, setup_tc, wait_tc;

  contador_de_espera #(.W(CNT_W)) u_setup_cnt (
    .clk        (clk),
    .rst        (rst),
    .i_clr      (cnt_clr),
    .i_load     (1'b0),
    .i_load_val ('0),
    .i_en       (setup_en),
    .i_term     (SETUP_TERM),
    .o_tc_c     (setup_tc)
  );

  contador_de_espera #(.W(CNT_W)) u_wait_cnt (
    .clk        (clk),
    .rst        (rst),
    .i_clr      (cnt_clr),
    .i_load     (1'b0),
    .i_load_val ('0),
    .i_en       (wait_en),
    .i_term     (WAIT_TERM),
    .o_tc_c     (wait_tc)
  );

  // Next state; outputs are decoded from the next state so they are registered.
  always_comb begin
    state_d  = state_q;
    sel_d    = sel_q;
    rw_d     = rw_q;
    rdata_d  = rdata_q;
    setup_en = 1'b0;
    wait_en  = 1'b0;
    cnt_clr  = (state_q == IDLE);

    unique case (state_q)
      IDLE: begin
        if (i_start) begin
          state_d = SETUP;
          sel_d   = i_sel;
          rw_d    = i_rw;
        end
      end
      SETUP: begin
        if (setup_tc) state_d = ACCESS;
        else          setup_en = 1'b1;
      end
      ACCESS: begin
        // Ready on the last allowed cycle still completes.
        if (i_bus_ready) begin
          state_d = DONE;
          if (rw_q == RW_READ) rdata_d = i_bus_rdata;
        end else if ((TIMEOUT != 0) && wait_tc) begin
          state_d = ERR;
        end else begin
          wait_en = 1'b1;
        end
      end
      DONE:    state_d = IDLE;
      ERR:     state_d = IDLE;
      default: state_d = IDLE;
    endcase

    sel_out_d = (state_d == IDLE) ? IDLE_SEL : sel_d;
    valid_d   = (state_d == ACCESS);
    busy_d    = (state_d != IDLE);
    done_d    = (state_d == DONE);
    error_d   = (state_d == ERR);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      sel_q     <= IDLE_SEL;
      rw_q      <= RW_READ;
      rdata_q   <= '0;
      sel_out_q <= IDLE_SEL;
      valid_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      error_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      sel_q     <= sel_d;
      rw_q      <= rw_d;
      rdata_q   <= rdata_d;
      sel_out_q <= sel_out_d;
      valid_q   <= valid_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      error_q   <= error_d;
    end
  end

  assign o_sel_salidas = sel_out_q;
  assign o_bus_valid   = valid_q;
  assign o_rdata       = rdata_q;
  assign o_busy        = busy_q;
  assign o_done        = done_q;
  assign o_error       = error_q;

endmodule

// File: tb/tb_controlador_de_salidas.sv
// Randomized self-checking bench for controlador_de_salidas using a
// cycle-timeline reference model of a transaction.
module tb_controlador_de_salidas;

  localparam int unsigned DW = 8;
  localparam int unsigned S  = 1;
  localparam int unsigned T  = 15;

  logic          clk = 1'b0;
  logic          rst;
  logic          i_start;
  logic [1:0]    i_sel;
  logic          i_rw;
  logic [1:0]    o_sel_salidas;
  logic          o_bus_valid;
  logic          i_bus_ready;
  logic [DW-1:0] i_bus_rdata;
  logic [DW-1:0] o_rdata;
  logic          o_busy;
  logic          o_done;
  logic          o_error;

  int            n_tests = 0;
  int            n_fail  = 0;
  logic [DW-1:0] m_rdata;

  always #5 clk = ~clk;

  controlador_de_salidas #(
    .DATA_W(DW), .SETUP_CYC(S), .TIMEOUT(T), .IDLE_SEL(2'd0)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .i_start       (i_start),
    .i_sel         (i_sel),
    .i_rw          (i_rw),
    .o_sel_salidas (o_sel_salidas),
    .o_bus_valid   (o_bus_valid),
    .i_bus_ready   (i_bus_ready),
    .i_bus_rdata   (i_bus_rdata),
    .o_rdata       (o_rdata),
    .o_busy        (o_busy),
    .o_done        (o_done),
    .o_error       (o_error)
  );

  // One transaction; w = wait states before ready, w < 0 or w >= T means no ready.
  // Cycle c counts from the start edge; noise scrambles inputs the DUT must ignore.
  task automatic run_txn(input logic [1:0] sel, input logic rw, input logic [DW-1:0] data,
                         input int w, input bit noise, input bit tail, input string name);
    bit   to;
    int   acc_end, last, n_cyc;
    logic e_busy, e_valid, e_done, e_err;
    logic [1:0] e_sel;
    to = (w < 0) || (w >= int'(T));
    if (to) begin
      acc_end = int'(S) + int'(T);
      last    = acc_end + 1;
    end else begin
      acc_end = int'(S) + 1 + w;
      last    = acc_end + 1;
    end
    n_cyc = tail ? last + 1 : last;
    i_start = 1'b1; i_sel = sel; i_rw = rw; i_bus_ready = 1'b0;
    @(posedge clk); #1;
    i_start = 1'b0;
    for (int c = 1; c <= n_cyc; c++) begin
      if (noise) begin
        i_sel   = 2'($urandom);
        i_rw    = 1'($urandom);
        i_start = (c <= last) ? 1'($urandom_range(0, 1)) : 1'b0;
      end
      if (c >= int'(S) + 1 && c <= acc_end) i_bus_ready = !to && (c == acc_end);
      else i_bus_ready = noise ? 1'($urandom_range(0, 1)) : 1'b0;
      i_bus_rdata = (!to && c == acc_end) ? data : DW'($urandom);
      if (!to && c == last && rw == 1'b0) m_rdata = data;
      e_busy  = (c <= last);
      e_sel   = (c <= last) ? sel : 2'd0;
      e_valid = (c >= int'(S) + 1) && (c <= acc_end);
      e_done  = (c == last) && !to;
      e_err   = (c == last) && to;
      @(negedge clk);
      n_tests++;
      if (o_busy !== e_busy) begin
        n_fail++; $display("FAIL %s busy cyc%0d: got %b exp %b", name, c, o_busy, e_busy);
      end
      n_tests++;
      if (o_sel_salidas !== e_sel) begin
        n_fail++; $display("FAIL %s sel cyc%0d: got %0d exp %0d", name, c, o_sel_salidas, e_sel);
      end
      n_tests++;
      if (o_bus_valid !== e_valid) begin
        n_fail++; $display("FAIL %s valid cyc%0d: got %b exp %b", name, c, o_bus_valid, e_valid);
      end
      n_tests++;
      if (o_done !== e_done) begin
        n_fail++; $display("FAIL %s done cyc%0d: got %b exp %b", name, c, o_done, e_done);
      end
      n_tests++;
      if (o_error !== e_err) begin
        n_fail++; $display("FAIL %s error cyc%0d: got %b exp %b", name, c, o_error, e_err);
      end
      n_tests++;
      if (o_rdata !== m_rdata) begin
        n_fail++; $display("FAIL %s rdata cyc%0d: got %h exp %h", name, c, o_rdata, m_rdata);
      end
      @(posedge clk); #1;
    end
    i_start = 1'b0;
    i_bus_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; i_start = 1'b0; i_sel = 2'd3; i_rw = 1'b0; i_bus_ready = 1'b0; i_bus_rdata = '0;
    m_rdata = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      n_tests++;
      if ({o_sel_salidas, o_bus_valid, o_busy, o_done, o_error} !== 6'd0 || o_rdata !== '0) begin
        n_fail++;
        $display("FAIL reset idle cyc%0d: got sel=%0d v=%b b=%b d=%b e=%b r=%h exp all 0",
                 c, o_sel_salidas, o_bus_valid, o_busy, o_done, o_error, o_rdata);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_write();
    run_txn(2'd2, 1'b1, 8'hC3, 0, 1'b0, 1'b1, "write");
  endtask

  task automatic test_read_waits();
    run_txn(2'd1, 1'b0, 8'h5A, 3, 1'b0, 1'b1, "read_w3");
  endtask

  task automatic test_timeout();
    run_txn(2'd3, 1'b0, 8'h11, -1, 1'b0, 1'b1, "timeout");
  endtask

  task automatic test_boundary();
    run_txn(2'd2, 1'b0, 8'hA7, int'(T) - 1, 1'b0, 1'b1, "boundary");
  endtask

  task automatic test_busy_start();
    run_txn(2'd1, 1'b0, 8'h3C, 2, 1'b1, 1'b1, "busy_start");
  endtask

  task automatic test_back_to_back();
    run_txn(2'd3, 1'b0, 8'h96, 0, 1'b0, 1'b0, "b2b_a");
    run_txn(2'd2, 1'b1, 8'h00, 1, 1'b0, 1'b1, "b2b_b");
  endtask

  task automatic test_random();
    for (int k = 0; k < 30; k++) begin
      run_txn(2'($urandom), 1'($urandom), DW'($urandom), int'($urandom_range(0, 18)),
              1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), "random");
    end
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic test_reset_mid();
    i_start = 1'b1; i_sel = 2'd3; i_rw = 1'b0; i_bus_ready = 1'b0;
    @(posedge clk); #1;
    i_start = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    n_tests++;
    if (o_bus_valid !== 1'b1) begin
      n_fail++; $display("FAIL rst_mid valid_before: got %b exp 1", o_bus_valid);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    m_rdata = '0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      n_tests++;
      if ({o_sel_salidas, o_bus_valid, o_busy, o_done, o_error} !== 6'd0 || o_rdata !== m_rdata) begin
        n_fail++;
        $display("FAIL rst_mid after cyc%0d: got sel=%0d v=%b b=%b d=%b e=%b r=%h exp all 0",
                 c, o_sel_salidas, o_bus_valid, o_busy, o_done, o_error, o_rdata);
      end
      @(posedge clk); #1;
    end
  endtask

  initial begin
    test_reset();
    test_write();
    test_read_waits();
    test_timeout();
    test_boundary();
    test_busy_start();
    test_back_to_back();
    test_random();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
